// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch family: state encoding and default
// time-field moduli used by both the up-counting and down-counting cores.
package stopwatch_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam int DEF_MSEC_COUNT = 100;
   localparam int DEF_SEC_COUNT  = 60;
   localparam int DEF_MIN_COUNT  = 60;
   localparam int DEF_HOUR_COUNT = 24;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_RUN   = ST_RUN,
      S_PAUSE = ST_PAUSE,
      S_DONE  = ST_DONE
   } state_e;

   function automatic int field_width(input int count);
      return (count <= 2) ? 1 : $clog2(count);
   endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control pulses in, time fields and status out, between the button/tick
// front end (master) and the countdown timer core (slave).
interface countdown_timer_if
   import stopwatch_pkg::*;
#(
   parameter int MSEC_W = field_width(DEF_MSEC_COUNT),
   parameter int SEC_W  = field_width(DEF_SEC_COUNT),
   parameter int MIN_W  = field_width(DEF_MIN_COUNT),
   parameter int HOUR_W = field_width(DEF_HOUR_COUNT)
) ();

   logic              tick;
   logic              run_stop;
   logic              clear;
   logic              add_sec;
   logic              add_min;
   logic              add_hour;
   logic [MSEC_W-1:0] o_msec;
   logic [SEC_W-1:0]  o_sec;
   logic [MIN_W-1:0]  o_min;
   logic [HOUR_W-1:0] o_hour;
   logic              o_running;
   logic              o_done;
   logic              o_alarm;

   modport master (
      output tick, run_stop, clear, add_sec, add_min, add_hour,
      input  o_msec, o_sec, o_min, o_hour, o_running, o_done, o_alarm
   );

   modport slave (
      input  tick, run_stop, clear, add_sec, add_min, add_hour,
      output o_msec, o_sec, o_min, o_hour, o_running, o_done, o_alarm
   );

endinterface

// File: rtl/down_counter.sv
// One time field: wraps on add, borrows downward, and reports a borrow to
// the next field when it is at zero and is asked to go lower.
module down_counter #(
   parameter int COUNT     = 10,
   parameter int BIT_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 borrow_in,
   input  logic                 clear,
   input  logic                 add,
   output logic [BIT_WIDTH-1:0] value,
   output logic                 borrow_out
);

   localparam logic [BIT_WIDTH-1:0] MAX_VAL = BIT_WIDTH'(COUNT - 1);
   localparam logic [BIT_WIDTH-1:0] ONE     = BIT_WIDTH'(1);

   logic [BIT_WIDTH-1:0] value_q;
   logic [BIT_WIDTH-1:0] value_d;

   always_comb begin
      value_d = value_q;
      if (clear) begin
         value_d = '0;
      end else if (add) begin
         value_d = (value_q == MAX_VAL) ? '0 : value_q + ONE;
      end else if (borrow_in) begin
         value_d = (value_q == '0) ? MAX_VAL : value_q - ONE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value      = value_q;
   assign borrow_out = borrow_in & (value_q == '0);

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer: four chained down_counter fields, the IDLE/RUN/PAUSE/DONE
// controller, zero detection and the registered done/alarm/running flags.
module countdown_timer
   import stopwatch_pkg::*;
#(
   parameter int MSEC_COUNT = DEF_MSEC_COUNT,
   parameter int SEC_COUNT  = DEF_SEC_COUNT,
   parameter int MIN_COUNT  = DEF_MIN_COUNT,
   parameter int HOUR_COUNT = DEF_HOUR_COUNT
) (
   input logic               clk,
   input logic               reset,
   countdown_timer_if.slave  bus
);

   localparam int MSEC_W = field_width(MSEC_COUNT);
   localparam int SEC_W  = field_width(SEC_COUNT);
   localparam int MIN_W  = field_width(MIN_COUNT);
   localparam int HOUR_W = field_width(HOUR_COUNT);

   logic [MSEC_W-1:0] msec_val;
   logic [SEC_W-1:0]  sec_val;
   logic [MIN_W-1:0]  min_val;
   logic [HOUR_W-1:0] hour_val;
   logic              msec_borrow;
   logic              sec_borrow;
   logic              min_borrow;
   logic              hour_borrow;

   state_e state_q, state_d;
   logic   done_q, done_d;
   logic   alarm_q, alarm_d;
   logic   running_q, running_d;

   logic upper_zero;
   logic zero_now;
   logic hit_zero;
   logic tick_en;
   logic add_en;
   logic field_clear;

   assign upper_zero = (sec_val == '0) && (min_val == '0) && (hour_val == '0);
   assign zero_now   = upper_zero && (msec_val == '0);
   assign tick_en    = bus.tick && (state_q == S_RUN);
   // This tick is the one that lands exactly on 00:00:00.00.
   assign hit_zero   = tick_en && upper_zero && (msec_val == MSEC_W'(1));
   assign add_en     = (state_q == S_IDLE) || (state_q == S_PAUSE);
   // A tick on an all-zero value would wrap to 23:59:59.99; pin at zero instead.
   assign field_clear = bus.clear || hour_borrow;

   down_counter #(.COUNT(MSEC_COUNT), .BIT_WIDTH(MSEC_W)) u_msec (
      .clk(clk), .reset(reset), .borrow_in(tick_en), .clear(field_clear),
      .add(1'b0), .value(msec_val), .borrow_out(msec_borrow)
   );

   down_counter #(.COUNT(SEC_COUNT), .BIT_WIDTH(SEC_W)) u_sec (
      .clk(clk), .reset(reset), .borrow_in(msec_borrow), .clear(field_clear),
      .add(add_en && bus.add_sec), .value(sec_val), .borrow_out(sec_borrow)
   );

   down_counter #(.COUNT(MIN_COUNT), .BIT_WIDTH(MIN_W)) u_min (
      .clk(clk), .reset(reset), .borrow_in(sec_borrow), .clear(field_clear),
      .add(add_en && bus.add_min), .value(min_val), .borrow_out(min_borrow)
   );

   down_counter #(.COUNT(HOUR_COUNT), .BIT_WIDTH(HOUR_W)) u_hour (
      .clk(clk), .reset(reset), .borrow_in(min_borrow), .clear(field_clear),
      .add(add_en && bus.add_hour), .value(hour_val), .borrow_out(hour_borrow)
   );

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      if (bus.clear) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.run_stop && !zero_now) state_d = S_RUN;
            end
            S_RUN: begin
               if (hit_zero) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else if (hour_borrow) begin
                  state_d = S_IDLE;
               end else if (bus.run_stop) begin
                  state_d = S_PAUSE;
               end
            end
            S_PAUSE: begin
               if (bus.run_stop) state_d = zero_now ? S_IDLE : S_RUN;
            end
            S_DONE: begin
               if (bus.run_stop) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
      alarm_d   = (state_d == S_DONE);
      running_d = (state_d == S_RUN);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         done_q    <= 1'b0;
         alarm_q   <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         done_q    <= done_d;
         alarm_q   <= alarm_d;
         running_q <= running_d;
      end
   end

   assign bus.o_msec    = msec_val;
   assign bus.o_sec     = sec_val;
   assign bus.o_min     = min_val;
   assign bus.o_hour    = hour_val;
   assign bus.o_running = running_q;
   assign bus.o_done    = done_q;
   assign bus.o_alarm   = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench: a total-centisecond reference model predicts each cycle,
// a monitor process compares DUT outputs one cycle after each stimulus.
module tb_countdown_timer;

   logic clk = 1'b0;
   logic reset = 1'b0;

   countdown_timer_if bus ();

   countdown_timer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cs;
      int s;
      int m;
      int h;
      bit run;
      bit done;
      bit alarm;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   txn    = 0;

   // Reference model: value held as whole centiseconds, mode as a small integer.
   int m_cs, m_s, m_m, m_h;
   int m_mode;   // 0 idle, 1 run, 2 pause, 3 done
   bit m_done;

   function automatic void model_reset();
      m_cs = 0; m_s = 0; m_m = 0; m_h = 0;
      m_mode = 0;
      m_done = 1'b0;
   endfunction

   function automatic void model_step(input bit t, input bit rs, input bit cl,
                                      input bit as, input bit am, input bit ah);
      int total;
      total  = ((m_h * 60 + m_m) * 60 + m_s) * 100 + m_cs;
      m_done = 1'b0;
      if (cl) begin
         model_reset();
      end else if (m_mode == 0 || m_mode == 2) begin
         if (as) m_s = (m_s + 1) % 60;
         if (am) m_m = (m_m + 1) % 60;
         if (ah) m_h = (m_h + 1) % 24;
         if (rs) m_mode = (total != 0) ? 1 : 0;
      end else if (m_mode == 1) begin
         if (t && total > 0) begin
            total = total - 1;
            m_cs  = total % 100;
            m_s   = (total / 100) % 60;
            m_m   = (total / 6000) % 60;
            m_h   = total / 360000;
            if (total == 0) begin
               m_mode = 3;
               m_done = 1'b1;
            end else if (rs) begin
               m_mode = 2;
            end
         end else if (rs) begin
            m_mode = 2;
         end
      end else begin
         if (rs) m_mode = 0;
      end
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      e.cs = m_cs; e.s = m_s; e.m = m_m; e.h = m_h;
      e.run   = (m_mode == 1);
      e.done  = m_done;
      e.alarm = (m_mode == 3);
      return e;
   endfunction

   task automatic cyc(input bit t, input bit rs, input bit cl,
                      input bit as, input bit am, input bit ah);
      @(negedge clk);
      reset        = 1'b1;
      bus.tick     = t;
      bus.run_stop = rs;
      bus.clear    = cl;
      bus.add_sec  = as;
      bus.add_min  = am;
      bus.add_hour = ah;
      model_step(t, rs, cl, as, am, ah);
      sb.push_back(model_out());
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset        = 1'b0;
      bus.tick     = 1'b0;
      bus.run_stop = 1'b0;
      bus.clear    = 1'b0;
      bus.add_sec  = 1'b0;
      bus.add_min  = 1'b0;
      bus.add_hour = 1'b0;
      #1;
      checks++;
      if ({bus.o_msec, bus.o_sec, bus.o_min, bus.o_hour,
           bus.o_running, bus.o_done, bus.o_alarm} != '0) begin
         errors++;
         $display("FAIL async_reset: got %0d:%0d:%0d.%0d run=%0b done=%0b alarm=%0b, want all 0",
                  bus.o_hour, bus.o_min, bus.o_sec, bus.o_msec,
                  bus.o_running, bus.o_done, bus.o_alarm);
      end else begin
         $display("txn async_reset: outputs all 0 ok");
      end
      model_reset();
      sb.push_back(model_out());
   endtask

   // Monitor: one expected entry per cycle, compared just after the clock edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            txn++;
            checks++;
            if (int'(bus.o_msec) != e.cs || int'(bus.o_sec) != e.s ||
                int'(bus.o_min) != e.m || int'(bus.o_hour) != e.h ||
                bus.o_running != e.run || bus.o_done != e.done ||
                bus.o_alarm != e.alarm) begin
               errors++;
               $display("FAIL txn %0d: got %02d:%02d:%02d.%02d run=%0b done=%0b alarm=%0b, want %02d:%02d:%02d.%02d run=%0b done=%0b alarm=%0b",
                        txn, bus.o_hour, bus.o_min, bus.o_sec, bus.o_msec,
                        bus.o_running, bus.o_done, bus.o_alarm,
                        e.h, e.m, e.s, e.cs, e.run, e.done, e.alarm);
            end else begin
               $display("txn %0d: %02d:%02d:%02d.%02d run=%0b done=%0b alarm=%0b ok",
                        txn, e.h, e.m, e.s, e.cs, e.run, e.done, e.alarm);
            end
         end
      end
   end

   initial begin
      int wait_cycles;
      bus.tick = 1'b0; bus.run_stop = 1'b0; bus.clear = 1'b0;
      bus.add_sec = 1'b0; bus.add_min = 1'b0; bus.add_hour = 1'b0;
      model_reset();

      // Two seconds, run to zero.
      do_reset();
      cyc(0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 1, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      ticks(200);
      idle_cycles(3);
      cyc(0, 0, 1, 0, 0, 0);

      // One minute, single tick borrows across two fields.
      cyc(0, 0, 0, 0, 1, 0);
      cyc(0, 1, 0, 0, 0, 0);
      ticks(1);
      cyc(0, 0, 1, 0, 0, 0);

      // Pause at 5 s, ticks ignored, add a minute, resume.
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      ticks(10);
      cyc(0, 0, 0, 0, 1, 0);
      cyc(0, 1, 0, 0, 0, 0);
      ticks(5);
      cyc(0, 0, 1, 0, 0, 0);

      // Zero value does not start; hours wrap on add.
      cyc(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 24; i++) cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 1, 1, 1);

      // tick+run_stop on the last centisecond, then clear+run_stop in DONE.
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      ticks(99);
      cyc(1, 1, 0, 0, 0, 0);
      idle_cycles(2);
      cyc(0, 1, 1, 0, 0, 0);

      // Reset in the middle of a run at 00:02:30.50.
      cyc(0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 31; i++) cyc(0, 0, 0, 1, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      ticks(50);
      do_reset();
      ticks(5);
      cyc(0, 1, 0, 0, 0, 0);
      ticks(3);

      // Random pulses.
      for (int i = 0; i < 3000; i++) begin
         cyc(1'($urandom_range(0, 1)),
             1'($urandom_range(0, 19) == 0),
             1'($urandom_range(0, 149) == 0),
             1'($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 15) == 0),
             1'($urandom_range(0, 63) == 0));
      end
      idle_cycles(1);

      wait_cycles = 0;
      while (sb.size() > 0 && wait_cycles < 20) begin
         @(posedge clk);
         wait_cycles++;
      end
      #2;
      if (sb.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d expected entries left, want 0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
